// File: rtl/uart_transmitter.sv
// uart_transmitter: start + DataBits (LSB first) + StopBits, no parity.
// Bit timing comes from definitions_pkg so TX and RX share one baud period.
//
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   data  - word to send, sampled only on valid && ready
//   valid - data is presented
//   ready - idle, a word can be accepted this cycle
//   tx    - serial line, idle high, driven from a flop
//   busy  - frame in progress (!ready)
//   done  - one-cycle pulse as the last stop bit completes

package definitions_pkg;
  localparam int CLOCK_RATE = 1_843_200;
  localparam int BAUD_RATE  = 230_400;
endpackage

module uart_transmitter
  import definitions_pkg::*;
#(
  parameter int DataBits = 8,
  parameter int StopBits = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DataBits-1:0] data,
  input  logic                valid,
  output logic                ready,
  output logic                tx,
  output logic                busy,
  output logic                done
);

  localparam int BaudPeriod = CLOCK_RATE / BAUD_RATE;
  localparam int CW =
    (BaudPeriod > 1) ? $clog2(BaudPeriod) : 1;
  localparam int IW = $clog2(DataBits + 1);

  localparam logic [CW-1:0] BaudLast =
    CW'(BaudPeriod - 1);
  localparam logic [CW-1:0] BaudLast2 =
    CW'(BaudPeriod - 2);
  localparam logic [IW-1:0] BitLast =
    IW'(DataBits - 1);
  localparam logic [IW-1:0] StopLast =
    IW'(StopBits - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  if (CLOCK_RATE % BAUD_RATE != 0) begin : g_rate
    $fatal(1, "CLOCK_RATE not a multiple of BAUD_RATE");
  end
  if (BaudPeriod < 2) begin : g_period
    $fatal(1, "BaudPeriod must be at least 2");
  end
  if (DataBits < 5 || DataBits > 9) begin : g_dbits
    $fatal(1, "DataBits out of range 5..9");
  end
  if (StopBits < 1 || StopBits > 2) begin : g_sbits
    $fatal(1, "StopBits out of range 1..2");
  end

  logic [1:0]          state;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [DataBits-1:0] shift;
  logic                bit_end;

  assign bit_end = (cnt == BaudLast);
  assign ready   = (state == IDLE);
  assign busy    = ~ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tx    <= 1'b1;
      done  <= 1'b0;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (valid) begin
            state <= START;
            tx    <= 1'b0;
            shift <= data;
            cnt   <= '0;
            idx   <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            tx    <= shift[0];
            shift <= shift >> 1;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == BitLast) begin
              state <= STOP;
              tx    <= 1'b1;
              idx   <= '0;
            end else begin
              tx    <= shift[0];
              shift <= shift >> 1;
              idx   <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Leave one cycle early: the final stop cycle is
          // spent in IDLE with ready high, so a waiting word
          // is accepted on the exact frame boundary.
          if (idx == StopLast && cnt == BaudLast2) begin
            state <= IDLE;
            done  <= 1'b1;
            cnt   <= '0;
            idx   <= '0;
          end else if (bit_end) begin
            cnt <= '0;
            idx <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: table-driven frame checks, corner sequences
// and a deserializer scoreboard on the 8N1 instance.

module tb_uart_transmitter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] data0;
  logic       valid0, ready0, tx0, busy0, done0;
  logic [6:0] data1;
  logic       valid1, ready1, tx1, busy1, done1;

  uart_transmitter #(.DataBits(8), .StopBits(1)) u0 (
    .clk(clk), .rst(rst), .data(data0), .valid(valid0),
    .ready(ready0), .tx(tx0), .busy(busy0), .done(done0)
  );

  uart_transmitter #(.DataBits(7), .StopBits(2)) u1 (
    .clk(clk), .rst(rst), .data(data1), .valid(valid1),
    .ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: expected bytes pushed on handshake
  logic [7:0] exp_q[$];
  int rx_cnt = 0;

  // receive-path synchronizer + reference deserializer
  logic s1, s2;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= tx0;
      s2 <= s1;
    end
  end

  logic       rx_on = 1'b0;
  int         rcnt = 0;
  logic [7:0] rsh = '0;
  always @(posedge clk) begin
    if (rst) begin
      rx_on <= 1'b0;
    end else if (!rx_on) begin
      if (!s2) begin
        rx_on <= 1'b1;
        rcnt  <= 1;
      end
    end else begin
      rcnt <= rcnt + 1;
      if (rcnt % 8 == 4) begin
        if (rcnt / 8 == 0) begin
          chk("rx_start", {31'd0, s2}, 32'd0);
        end else if (rcnt / 8 <= 8) begin
          rsh[rcnt/8-1] <= s2;
        end else begin
          chk("rx_stop", {31'd0, s2}, 32'd1);
          rx_on <= 1'b0;
          rx_cnt++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rx_extra: got %0h want none", rsh);
          end else begin
            chk("rx_byte", {24'd0, rsh},
                {24'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  int done_at[$];
  always @(negedge clk) begin
    if (done0 === 1'b1) done_at.push_back(cyc);
  end

  // returns n = edge number of the handshake
  task automatic xfer0(input logic [7:0] d,
                       input bit keep,
                       output int n);
    @(negedge clk);
    data0  = d;
    valid0 = 1'b1;
    n = -1;
    for (int i = 0; i < 300; i++) begin
      if (ready0) begin
        n = cyc + 1;
        exp_q.push_back(d);
        break;
      end
      @(negedge clk);
    end
    if (n < 0) begin
      total++;
      bad++;
      $display("FAIL xfer_timeout: got ready=0 want 1");
      valid0 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!keep) valid0 = 1'b0;
  endtask

  task automatic check_frame0(input logic [9:0] f);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      chk("frame_tx", {31'd0, tx0}, {31'd0, f[c/8]});
      if (c % 8 == 0 || c >= 78) begin
        chk("frame_ready", {31'd0, ready0},
            (c == 79) ? 32'd1 : 32'd0);
      end
      if (c >= 78) begin
        chk("frame_done", {31'd0, done0},
            (c == 79) ? 32'd1 : 32'd0);
      end
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic [9:0] f;
  } vec_t;

  vec_t vt[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n1, n2, r0, d0, low;
    logic [9:0] f1;

    vt[0] = '{8'h55, 10'b1010101010};
    vt[1] = '{8'h00, 10'b1000000000};
    vt[2] = '{8'hFF, 10'b1111111110};
    vt[3] = '{8'h01, 10'b1000000010};
    vt[4] = '{8'h80, 10'b1100000000};

    rst = 1'b1;
    valid0 = 1'b0;
    data0 = '0;
    valid1 = 1'b0;
    data1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx0}, 32'd1);
    chk("rst_ready", {31'd0, ready0}, 32'd1);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      xfer0(vt[i].d, 1'b0, n);
      check_frame0(vt[i].f);
      repeat (3) @(negedge clk);
    end

    // back-to-back with valid held high
    done_at.delete();
    xfer0(8'hA5, 1'b1, n1);
    xfer0(8'h3C, 1'b0, n2);
    chk("b2b_gap", n2 - n1, 32'd80);
    chk("b2b_start", {31'd0, tx0}, 32'd0);
    repeat (100) @(negedge clk);
    chk("b2b_ndone", done_at.size(), 32'd2);
    if (done_at.size() >= 2) begin
      chk("b2b_done0", done_at[0], n1 + 79);
      chk("b2b_ddone", done_at[1] - done_at[0], 32'd80);
    end

    // valid + new data while busy is ignored
    r0 = rx_cnt;
    d0 = done_at.size();
    xfer0(8'h96, 1'b0, n);
    repeat (10) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      data0 = 8'hFF;
      valid0 = 1'b1;
      chk("hold_ready", {31'd0, ready0}, 32'd0);
      @(negedge clk);
    end
    valid0 = 1'b0;
    data0 = '0;
    repeat (40) @(negedge clk);
    chk("hold_ready_mid", {31'd0, ready0}, 32'd0);
    repeat (100) @(negedge clk);
    chk("hold_rx", rx_cnt - r0, 32'd1);
    chk("hold_ndone", done_at.size() - d0, 32'd1);
    chk("hold_q", exp_q.size(), 32'd0);

    // asynchronous reset during a 0 data bit
    xfer0(8'hF0, 1'b0, n);
    repeat (20) @(negedge clk);
    chk("mid_tx_low", {31'd0, tx0}, 32'd0);
    rst = 1'b1;
    #1;
    chk("arst_tx", {31'd0, tx0}, 32'd1);
    chk("arst_ready", {31'd0, ready0}, 32'd1);
    chk("arst_busy", {31'd0, busy0}, 32'd0);
    chk("arst_done", {31'd0, done0}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    low = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx0 !== 1'b1) low++;
    end
    chk("post_rst_quiet", low, 32'd0);
    chk("post_rst_ready", {31'd0, ready0}, 32'd1);

    // 7 data bits, 2 stop bits, 0x41
    f1 = 10'b1110000010;
    @(negedge clk);
    data1 = 7'h41;
    valid1 = 1'b1;
    n = -1;
    for (int i = 0; i < 50; i++) begin
      if (ready1) begin
        n = 0;
        break;
      end
      @(negedge clk);
    end
    chk("s2_accept", n, 32'd0);
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    data1 = 7'h7F;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      chk("s2_tx", {31'd0, tx1}, {31'd0, f1[c/8]});
      if (c >= 78) begin
        chk("s2_done", {31'd0, done1},
            (c == 79) ? 32'd1 : 32'd0);
        chk("s2_ready", {31'd0, ready1},
            (c == 79) ? 32'd1 : 32'd0);
      end
    end
    @(negedge clk);
    chk("s2_idle_tx", {31'd0, tx1}, 32'd1);
    chk("s2_done_off", {31'd0, done1}, 32'd0);

    // loopback of every byte value, back-to-back
    r0 = rx_cnt;
    for (int i = 0; i < 256; i++) begin
      xfer0(8'(i), (i != 255), n);
    end
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("loop_q", exp_q.size(), 32'd0);
    chk("loop_cnt", rx_cnt - r0, 32'd256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
